// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search_pkg;

    // Default probe/result width and the top of the search range.
    localparam int unsigned SAR_WIDTH = 4;
    localparam int unsigned PROBE_MAX = (2 ** SAR_WIDTH) - 1;

    // Search controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_t;

    // Comparator flag patterns as {A_eq_B, A_gt_B, A_lt_B}.
    localparam logic [2:0] FLAGS_EQ = 3'b100;
    localparam logic [2:0] FLAGS_GT = 3'b010;
    localparam logic [2:0] FLAGS_LT = 3'b001;

endpackage

// File: rtl/sar_search_if.sv
// Handshake, probe and comparator-flag bundle between the search engine and its user.
interface sar_search_if
    import sar_search_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
);
    logic             start;
    logic             A_eq_B;
    logic             A_gt_B;
    logic             A_lt_B;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;

    // Requester side: issues start, supplies comparator flags, observes the search.
    modport master (
        output start,
        output A_eq_B,
        output A_gt_B,
        output A_lt_B,
        input  probe,
        input  busy,
        input  done,
        input  found,
        input  err,
        input  result
    );

    // Search engine side.
    modport slave (
        input  start,
        input  A_eq_B,
        input  A_gt_B,
        input  A_lt_B,
        output probe,
        output busy,
        output done,
        output found,
        output err,
        output result
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search engine: binary-searches an unknown comparator target
// by driving probe values onto the comparator b input, one probe per cycle.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
) (
    input logic         clk,
    input logic         rst,
    sar_search_if.slave bus
);

    // Upper search bound, kept WIDTH+1 bits wide like lo/hi.
    localparam logic [WIDTH:0] HiMax = {1'b0, {WIDTH{1'b1}}};

    state_t           state_q;
    logic [WIDTH:0]   lo_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] probe_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic             err_q;

    logic [2:0]       flags;
    logic [WIDTH:0]   probe_ext;
    logic [WIDTH:0]   probe_inc;
    logic [WIDTH:0]   probe_dec;

    // Midpoint of [a, b]; the extra sum bit keeps lo+hi from overflowing.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [WIDTH+1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    assign flags     = {bus.A_eq_B, bus.A_gt_B, bus.A_lt_B};
    assign probe_ext = {1'b0, probe_q};
    // probe_inc may reach 2**WIDTH and probe_dec may go all-ones at probe 0; both are caught by
    // the range-empty tests below before they can be used as a new probe.
    assign probe_inc = probe_ext + 1'b1;
    assign probe_dec = probe_ext - 1'b1;

    // Search controller: state, bounds and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        lo_q    <= '0;
                        hi_q    <= HiMax;
                        probe_q <= mid('0, HiMax);
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSearch;
                    end
                end
                StSearch: begin
                    case (flags)
                        FLAGS_EQ: begin
                            result_q <= probe_q;
                            found_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                        FLAGS_GT: begin
                            lo_q <= probe_inc;
                            if (probe_inc > hi_q) begin
                                found_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                probe_q <= mid(probe_inc, hi_q);
                            end
                        end
                        FLAGS_LT: begin
                            hi_q <= probe_dec;
                            if (probe_ext == lo_q) begin
                                found_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                probe_q <= mid(lo_q, probe_dec);
                            end
                        end
                        default: begin
                            // No flag or several flags: comparator output is not trustworthy.
                            err_q   <= 1'b1;
                            found_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    endcase
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.probe  = probe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed table, handshake corner cases, exhaustive
// target sweep and randomized runs against a range-halving reference model.
module tb_sar_search;
    import sar_search_pkg::*;

    localparam int MReal = 0;  // real 4-bit comparator, a=target, b=probe
    localparam int MGt   = 1;  // stub: A_gt_B always
    localparam int MEqGt = 2;  // stub: A_eq_B and A_gt_B
    localparam int MZero = 3;  // stub: no flags

    logic clk;
    logic rst;
    sar_search_if #(.WIDTH(4)) bus ();

    sar_search #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cur_mode;
    int cur_target;

    // Comparator (or stub) feeding flags back from the current probe.
    always_comb begin
        case (cur_mode)
            MReal: begin
                bus.A_eq_B = (cur_target == int'(bus.probe));
                bus.A_gt_B = (cur_target >  int'(bus.probe));
                bus.A_lt_B = (cur_target <  int'(bus.probe));
            end
            MGt:   {bus.A_eq_B, bus.A_gt_B, bus.A_lt_B} = 3'b010;
            MEqGt: {bus.A_eq_B, bus.A_gt_B, bus.A_lt_B} = 3'b110;
            default: {bus.A_eq_B, bus.A_gt_B, bus.A_lt_B} = 3'b000;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observed run.
    int obs_probes[$];
    int obs_done_cyc;
    int obs_found;
    int obs_err;
    int obs_result;

    // Reference model outcome.
    int m_probes[$];
    int m_found;
    int m_err;
    int m_res;
    int held_result;

    // Spec-level model: halve the candidate range [lo, hi] until the target is hit,
    // the range empties, or the flags are not one-hot.
    task automatic model(input int mode, input int tgt);
        int lo;
        int hi;
        int p;
        bit eq;
        bit gt;
        bit lt;
        lo = 0;
        hi = PROBE_MAX;
        m_probes.delete();
        m_found = 0;
        m_err = 0;
        m_res = 0;
        forever begin
            p = (lo + hi) / 2;
            m_probes.push_back(p);
            case (mode)
                MReal:   begin eq = (tgt == p); gt = (tgt > p); lt = (tgt < p); end
                MGt:     begin eq = 0; gt = 1; lt = 0; end
                MEqGt:   begin eq = 1; gt = 1; lt = 0; end
                default: begin eq = 0; gt = 0; lt = 0; end
            endcase
            if (int'(eq) + int'(gt) + int'(lt) != 1) begin
                m_err = 1;
                return;
            end
            if (eq) begin
                m_found = 1;
                m_res = p;
                return;
            end
            if (gt) lo = p + 1;
            else    hi = p - 1;
            if (lo > hi) return;
        end
    endtask

    // Issue one start pulse (or hold start through the search) and record the run.
    task automatic run_search(input int mode, input int tgt, input bit hold);
        cur_mode = mode;
        cur_target = tgt;
        obs_probes.delete();
        obs_done_cyc = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.busy) obs_probes.push_back(int'(bus.probe));
            if (bus.done) begin
                obs_done_cyc = c;
                obs_found = int'(bus.found);
                obs_err = int'(bus.err);
                obs_result = int'(bus.result);
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    // Compare the recorded run against the model, then check the done pulse width and hold.
    task automatic compare_model(input string name);
        check({name, " probe count"}, obs_probes.size(), m_probes.size());
        for (int i = 0; i < m_probes.size() && i < obs_probes.size(); i++)
            check($sformatf("%s probe[%0d]", name, i), obs_probes[i], m_probes[i]);
        check({name, " done cycle"}, obs_done_cyc, m_probes.size() + 1);
        check({name, " found"}, obs_found, m_found);
        check({name, " err"}, obs_err, m_err);
        if (m_found) held_result = m_res;
        check({name, " result"}, obs_result, held_result);
        @(negedge clk);
        check({name, " done pulse"}, bus.done, 0);
        check({name, " busy after"}, bus.busy, 0);
        check({name, " result held"}, bus.result, held_result);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    tgt;
        int    n;
        int    found;
        int    err;
        int    res;   // -1: result keeps its previous value
    } vec_t;

    vec_t tbl[6];
    int   probe_max_seen;

    initial begin
        tbl[0] = '{"t7",     MReal, 7,  1, 1, 0, 7};
        tbl[1] = '{"t0",     MReal, 0,  4, 1, 0, 0};
        tbl[2] = '{"t15",    MReal, 15, 5, 1, 0, 15};
        tbl[3] = '{"gtstub", MGt,   0,  5, 0, 0, -1};
        tbl[4] = '{"eqgt",   MEqGt, 0,  1, 0, 1, -1};
        tbl[5] = '{"zero",   MZero, 0,  1, 0, 1, -1};

        cur_mode = MReal;
        cur_target = 0;
        held_result = 0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset probe", bus.probe, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset found", bus.found, 0);
        check("reset err", bus.err, 0);
        check("reset result", bus.result, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle without start", bus.busy, 0);

        // Directed table with literal expectations plus model cross-check.
        for (int i = 0; i < 6; i++) begin
            int prev_res;
            prev_res = held_result;
            run_search(tbl[i].mode, tbl[i].tgt, 1'b0);
            model(tbl[i].mode, tbl[i].tgt);
            check({tbl[i].name, " tbl n"}, obs_probes.size(), tbl[i].n);
            check({tbl[i].name, " tbl done"}, obs_done_cyc, tbl[i].n + 1);
            check({tbl[i].name, " tbl found"}, obs_found, tbl[i].found);
            check({tbl[i].name, " tbl err"}, obs_err, tbl[i].err);
            check({tbl[i].name, " tbl result"}, obs_result,
                  (tbl[i].res < 0) ? prev_res : tbl[i].res);
            compare_model(tbl[i].name);
        end
        check("gtstub last probe no wrap", obs_probes.size() > 0 ? 0 : 1, 0);

        // start held high for the whole search and its DONE cycle must be ignored.
        run_search(MReal, 9, 1'b1);
        model(MReal, 9);
        compare_model("held start");
        repeat (2) @(negedge clk);
        check("held start no restart", bus.busy, 0);

        // Reset on the second probe of a target-0 search.
        cur_mode = MReal;
        cur_target = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("rst 1st probe", bus.probe, 7);
        @(negedge clk);
        check("rst 2nd probe", bus.probe, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_result = 0;
        check("rst probe", bus.probe, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst found", bus.found, 0);
        check("rst err", bus.err, 0);
        check("rst result", bus.result, 0);
        @(negedge clk);
        check("rst stays idle", bus.busy, 0);
        run_search(MReal, 0, 1'b0);
        model(MReal, 0);
        compare_model("after rst");

        // Every target with the real comparator.
        probe_max_seen = 0;
        for (int t = 0; t <= int'(PROBE_MAX); t++) begin
            run_search(MReal, t, 1'b0);
            model(MReal, t);
            compare_model($sformatf("sweep t%0d", t));
            check($sformatf("sweep t%0d result", t), obs_result, t);
            if (obs_probes.size() > probe_max_seen) probe_max_seen = obs_probes.size();
        end
        check("sweep probes <= 5", probe_max_seen <= 5, 1);

        // Randomized comparator modes and targets.
        for (int r = 0; r < 40; r++) begin
            int mode;
            int tgt;
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : MReal;
            tgt = int'($urandom_range(0, PROBE_MAX));
            run_search(mode, tgt, 1'b0);
            model(mode, tgt);
            compare_model($sformatf("rand%0d m%0d t%0d", r, mode, tgt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
